// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle command sequencer that drives the datapath ALU.
//
// It accepts ADD/SUB/AND/OR/MUL commands over a valid/ready handshake and
// issues each one to the external ALU. It captures the 32-bit ALU result and
// its carry/borrow flag, then returns them over a second valid/ready
// handshake. MUL is an unsigned shift-and-add built from 32 repeated ALU adds.
//
// Build option: define ALU_SEQ_MUL_EN to include the multiply. Without it,
// op 100 is reported as illegal.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only when idle)
//   cmd_op[2:0], cmd_a, cmd_b    opcode and operands, latched on accept
//   rsp_valid/rsp_ready          response handshake
//   rsp_data, rsp_flag, rsp_err  result, ALU flag (sticky for MUL), error
//   alu_op, alu_a, alu_b         to the ALU (zero outside EXEC/MUL)
//   alu_out, alu_flag            from the ALU
module alu_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_flag,
   output logic        rsp_err,
   output logic [1:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_out,
   input  logic        alu_flag
);

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic [1:0] {StIdle, StExec, StResp, StMul} state_t;
`else
   typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;
`endif

   state_t      r_state;
   logic [1:0]  r_op;
   logic [31:0] r_a;      // operand A; doubles as the shifting multiplicand
   logic [31:0] r_b;      // operand B; doubles as the shifting multiplier
   logic        r_ill;    // latched illegal-op marker
   logic [31:0] r_data;
   logic        r_flag;
   logic        r_err;
   logic        w_illegal;

`ifdef ALU_SEQ_MUL_EN
   logic [31:0] r_acc;
   logic [4:0]  r_count;
   logic        r_sticky;

   assign w_illegal = cmd_op[2] && (cmd_op[1:0] != 2'b00);
`else
   assign w_illegal = cmd_op[2];
`endif

   // Outputs depend only on the state register and internal registers.
   assign cmd_ready = (r_state == StIdle);
   assign rsp_valid = (r_state == StResp);
   assign rsp_data  = r_data;
   assign rsp_flag  = r_flag;
   assign rsp_err   = r_err;

   always_comb begin
      alu_op = 2'b00;
      alu_a  = 32'd0;
      alu_b  = 32'd0;
      case (r_state)
         StExec: begin
            if (!r_ill) begin
               alu_op = r_op;
               alu_a  = r_a;
               alu_b  = r_b;
            end
         end
`ifdef ALU_SEQ_MUL_EN
         StMul: begin
            alu_a = r_acc;
            alu_b = r_b[0] ? r_a : 32'd0;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= StIdle;
         r_op     <= 2'b00;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_ill    <= 1'b0;
         r_data   <= 32'd0;
         r_flag   <= 1'b0;
         r_err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         r_acc    <= 32'd0;
         r_count  <= 5'd0;
         r_sticky <= 1'b0;
`endif
      end else begin
         case (r_state)
            StIdle: begin
               if (cmd_valid) begin
                  r_op  <= cmd_op[1:0];
                  r_a   <= cmd_a;
                  r_b   <= cmd_b;
                  r_ill <= w_illegal;
                  // Illegal ops pass through EXEC with the ALU idle so the
                  // error response appears one cycle after accept, like
                  // every other single-cycle op.
                  r_state <= StExec;
`ifdef ALU_SEQ_MUL_EN
                  if (cmd_op == 3'b100) begin
                     r_acc    <= 32'd0;
                     r_count  <= 5'd0;
                     r_sticky <= 1'b0;
                     r_state  <= StMul;
                  end
`endif
               end
            end
            StExec: begin
               r_data  <= r_ill ? 32'd0 : alu_out;
               r_flag  <= r_ill ? 1'b0 : alu_flag;
               r_err   <= r_ill;
               r_state <= StResp;
            end
`ifdef ALU_SEQ_MUL_EN
            StMul: begin
               r_acc    <= alu_out;
               r_sticky <= r_sticky | alu_flag;
               r_a      <= r_a << 1;
               r_b      <= r_b >> 1;
               r_count  <= r_count + 5'd1;
               if (r_count == 5'd31) begin
                  r_data  <= alu_out;
                  r_flag  <= r_sticky | alu_flag;
                  r_err   <= 1'b0;
                  r_state <= StResp;
               end
            end
`endif
            StResp: begin
               if (rsp_ready) begin
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule
